// File: rtl/song_sequencer.sv
// Song ROM sequencer: walks a 64-entry song, handing each note's tone period and
// gate to a tone divider for its coded duration, with loop, stop and done handling.
module song_sequencer #(
  parameter int unsigned TICK_CYCLES = 6250000,
  parameter int unsigned GAP_CYCLES  = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  song_sel,
  input  logic        loop,
  output logic [7:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic [19:0] note_period,
  output logic        play,
  output logic        busy,
  output logic [5:0]  mem_loc,
  output logic        done
);

  localparam int unsigned CW = $clog2(8 * TICK_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     song_q, song_d;
  logic [5:0]     idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     dur_q, dur_d;
  logic [19:0]    period_q, period_d;
  logic           play_q, play_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           end_flag;
  logic [19:0]    rom_period;
  logic [CW-1:0]  note_len;
  logic           last_cyc;
  logic           unused_rom_bit;

  assign end_flag       = rom_data[21];
  assign rom_period     = rom_data[19:0];
  assign unused_rom_bit = rom_data[20];
  assign note_len       = CW'(TICK_CYCLES) << dur_q;
  assign last_cyc       = (cnt_q == note_len - CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; stop overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !stop) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (end_flag) state_d = loop ? S_FETCH : S_DONE;
        else          state_d = S_PLAY;
      end
      S_PLAY: begin
        if (last_cyc) state_d = (idx_q == 6'd63 && !loop) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
  end

  // Datapath and next output values
  always_comb begin
    song_d   = song_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    dur_d    = dur_q;
    period_d = period_q;
    play_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          song_d = song_sel;
          idx_d  = 6'd0;
        end
      end
      S_LOAD: begin
        if (end_flag) begin
          if (loop) idx_d = 6'd0;
          else      period_d = 20'd0;
        end else begin
          period_d = rom_period;
          dur_d    = rom_data[23:22];
          cnt_d    = CW'(0);
          play_d   = (rom_period != 20'd0);
        end
      end
      S_PLAY: begin
        if (last_cyc) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63 && !loop) period_d = 20'd0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          play_d = (period_q != 20'd0) &&
                   (cnt_q + CW'(1) < note_len - CW'(GAP_CYCLES));
        end
      end
      default: ;
    endcase
    if (stop) begin
      period_d = 20'd0;
      play_d   = 1'b0;
      cnt_d    = CW'(0);
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q   <= 2'd0;
      idx_q    <= 6'd0;
      cnt_q    <= CW'(0);
      dur_q    <= 2'd0;
      period_q <= 20'd0;
      play_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      song_q   <= song_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      dur_q    <= dur_d;
      period_q <= period_d;
      play_q   <= play_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr    = {song_q, idx_q};
  assign note_period = period_q;
  assign play        = play_q;
  assign busy        = busy_q;
  assign mem_loc     = idx_q;
  assign done        = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_CYCLES=4, GAP_CYCLES=1 and a
// behavioural synchronous song ROM.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [1:0]  song_sel;
  logic        loop;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [19:0] note_period;
  logic        play;
  logic        busy;
  logic [5:0]  mem_loc;
  logic        done;

  logic [23:0] rom [256];

  int n_vec = 0;
  int n_err = 0;

  song_sequencer #(.TICK_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .song_sel(song_sel),
    .loop(loop), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_period(note_period), .play(play), .busy(busy), .mem_loc(mem_loc),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the FETCH cycle (n+1)
  task automatic start_song(input logic [1:0] sel);
    start    = 1'b1;
    song_sel = sel;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int done_off;
    int exp_loc;
    logic seen;

    for (int i = 0; i < 256; i++) rom[i] = 24'h0;
    rom[8'h80] = {2'd1, 1'b0, 1'b0, 20'h01000};
    rom[8'h81] = {2'd0, 1'b1, 1'b0, 20'h00000};
    rom[8'h40] = {2'd0, 1'b0, 1'b0, 20'h00000};
    rom[8'h41] = {2'd0, 1'b0, 1'b0, 20'h00123};
    rom[8'h42] = {2'd0, 1'b1, 1'b0, 20'h00000};
    rom[8'hC0] = {2'd0, 1'b0, 1'b0, 20'h00005};
    rom[8'hC1] = {2'd0, 1'b0, 1'b0, 20'h00006};
    rom[8'hC2] = {2'd0, 1'b1, 1'b0, 20'h00000};
    for (int i = 0; i < 64; i++) rom[i] = {2'd0, 1'b0, 1'b0, 20'(i + 1)};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; song_sel = 2'd0; loop = 1'b0;
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_period", 32'(note_period), 32'h0);
    chk("rst_play", 32'(play), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_loc", 32'(mem_loc), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // One 2-tick note on song 2 then end flag
    start_song(2'd2);
    chk("s2_fetch_addr", 32'(rom_addr), 32'h80);
    chk("s2_fetch_busy", 32'(busy), 32'h1);
    chk("s2_fetch_play", 32'(play), 32'h0);
    tick();
    chk("s2_load_play", 32'(play), 32'h0);
    chk("s2_load_period", 32'(note_period), 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("s2_play", 32'(play), 32'(k < 7));
      chk("s2_period", 32'(note_period), 32'h1000);
    end
    tick();
    chk("s2_fetch2_addr", 32'(rom_addr), 32'h81);
    chk("s2_fetch2_loc", 32'(mem_loc), 32'h1);
    chk("s2_fetch2_play", 32'(play), 32'h0);
    chk("s2_hold_period", 32'(note_period), 32'h1000);
    tick();
    chk("s2_load2_done", 32'(done), 32'h0);
    tick();
    chk("s2_done_pulse", 32'(done), 32'h1);
    chk("s2_done_busy", 32'(busy), 32'h1);
    tick();
    chk("s2_done_clear", 32'(done), 32'h0);
    chk("s2_idle_busy", 32'(busy), 32'h0);

    // Rest entry followed by a 1-tick note on song 1
    start_song(2'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rest_play", 32'(play), 32'h0);
      chk("rest_loc", 32'(mem_loc), 32'h0);
    end
    tick();
    chk("rest_next_loc", 32'(mem_loc), 32'h1);
    chk("rest_next_play", 32'(play), 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s1_play", 32'(play), 32'(k < 3));
      chk("s1_period", 32'(note_period), 32'h123);
    end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("s1_done_seen", 32'(seen), 32'h1);
    tick();

    // Looping 2-note song: 14-cycle period, mem_loc 0 x6, 1 x6, 2 x2
    loop = 1'b1;
    start_song(2'd3);
    for (int off = 0; off < 42; off++) begin
      if (off > 0) tick();
      exp_loc = (off % 14 < 6) ? 0 : (off % 14 < 12) ? 1 : 2;
      chk("loop_loc", 32'(mem_loc), 32'(exp_loc));
      chk("loop_no_done", 32'(done), 32'h0);
    end
    tick(); tick(); tick();
    chk("loop_play", 32'(play), 32'h1);
    chk("loop_period", 32'(note_period), 32'h5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_play", 32'(play), 32'h0);
    chk("stop_period", 32'(note_period), 32'h0);
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stop_done", 32'(done), 32'h0);
    loop = 1'b0;
    tick();
    chk("stop_stay_idle", 32'(busy), 32'h0);

    // Simultaneous start and stop in IDLE
    start = 1'b1; stop = 1'b1; song_sel = 2'd2;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("both_busy", 32'(busy), 32'h0);
    chk("both_play", 32'(play), 32'h0);
    tick();
    chk("both_stay_idle", 32'(busy), 32'h0);
    chk("both_song_kept", 32'(rom_addr >> 6), 32'h3);

    // Start while busy is ignored
    start_song(2'd2);
    tick(); tick();
    start = 1'b1; song_sel = 2'd1;
    tick();
    start = 1'b0;
    chk("busy_start_song", 32'(rom_addr), 32'h80);
    chk("busy_start_busy", 32'(busy), 32'h1);
    chk("busy_start_play", 32'(play), 32'h1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("busy_stop_busy", 32'(busy), 32'h0);

    // 64 entries with no end flag: DONE right after entry 63
    start_song(2'd0);
    done_off = -1;
    for (int off = 0; off < 500 && done_off < 0; off++) begin
      if (off > 0) tick();
      if (off == 380) chk("s0_loc63", 32'(mem_loc), 32'd63);
      if (done) done_off = off;
    end
    chk("s0_done_offset", 32'(done_off), 32'd384);
    tick();
    chk("s0_done_clear", 32'(done), 32'h0);
    chk("s0_idle_busy", 32'(busy), 32'h0);

    // Asynchronous reset mid-note
    start_song(2'd0);
    tick(); tick(); tick();
    chk("prerst_play", 32'(play), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_play", 32'(play), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_period", 32'(note_period), 32'h0);
    chk("arst_rom_addr", 32'(rom_addr), 32'h0);
    chk("arst_mem_loc", 32'(mem_loc), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_play", 32'(play), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
